// File: rtl/sort_input_loader.sv
// Collects four values over a valid/ready handshake into x0..x3, pulses load,
// waits SORT_CYCLES for the attached sorter, then pulses done.
module sort_input_loader #(
    parameter int W           = 3,
    parameter int SORT_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic         abort,
    output logic [W-1:0] x0,
    output logic [W-1:0] x1,
    output logic [W-1:0] x2,
    output logic [W-1:0] x3,
    output logic         load,
    output logic         busy,
    output logic         done,
    output logic [1:0]   count
);

    localparam int CW = $clog2(SORT_CYCLES) + 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(SORT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_COLLECT,
        S_LOAD,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [1:0]    cnt;
    logic [W-1:0]  x_r [4];
    logic          load_r;
    logic          busy_r;
    logic          done_r;

    // load/busy/done are registered alongside the state they belong to, so they
    // switch on the same edge as the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_COLLECT;
            wait_cnt <= '0;
            cnt      <= '0;
            load_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                x_r[i] <= '0;
            end
        end else begin
            load_r <= 1'b0;
            done_r <= 1'b0;
            case (state)
                S_COLLECT: begin
                    if (abort) begin
                        cnt <= '0;
                    end else if (din_valid) begin
                        x_r[cnt] <= din;
                        if (cnt == 2'd3) begin
                            cnt    <= '0;
                            state  <= S_LOAD;
                            load_r <= 1'b1;
                            busy_r <= 1'b1;
                        end else begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                end
                S_LOAD: begin
                    state    <= S_WAIT;
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    if (wait_cnt == WAIT_LAST) begin
                        state  <= S_DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_COLLECT;
                end
                default: begin
                    state <= S_COLLECT;
                end
            endcase
        end
    end

    // Held low during reset so no source sees a ready while state is being cleared.
    assign din_ready = (state == S_COLLECT) && !rst;

    assign x0    = x_r[0];
    assign x1    = x_r[1];
    assign x2    = x_r[2];
    assign x3    = x_r[3];
    assign load  = load_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign count = cnt;

endmodule

// File: tb/tb_sort_input_loader.sv
// Self-checking bench for sort_input_loader: directed scenarios plus random
// traffic, compared every cycle against a queue-based batch model.
module tb_sort_input_loader;

    localparam int W  = 3;
    localparam int SC = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         abort;
    logic [W-1:0] x0, x1, x2, x3;
    logic         load, busy, done;
    logic [1:0]   count;

    always #5 clk = ~clk;

    sort_input_loader #(.W(W), .SORT_CYCLES(SC)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .abort     (abort),
        .x0        (x0),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .load      (load),
        .busy      (busy),
        .done      (done),
        .count     (count)
    );

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_done = 0;

    // Model: values collected so far in the batch, the operand registers, and
    // cycles elapsed since the 4th accept (-1 while collecting).
    int m_q[$];
    int m_x[4];
    int since;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        for (int i = 0; i < 4; i++) m_x[i] = 0;
        since = -1;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_clear();
        end else if (since < 0) begin
            if (abort) begin
                m_q.delete();
            end else if (din_valid) begin
                m_q.push_back(int'(din));
                m_x[m_q.size() - 1] = int'(din);
                if (m_q.size() == 4) begin
                    m_q.delete();
                    since = 0;
                end
            end
        end else begin
            since++;
            if (since == SC + 2) since = -1;
        end
    endtask

    task automatic check_outputs();
        check("count", int'(count), m_q.size());
        check("load",  int'(load),  int'(since == 0));
        check("busy",  int'(busy),  int'(since >= 0 && since <= SC));
        check("done",  int'(done),  int'(since == SC + 1));
        check("ready", int'(din_ready), int'(since < 0 && !rst));
        check("x0", int'(x0), m_x[0]);
        check("x1", int'(x1), m_x[1]);
        check("x2", int'(x2), m_x[2]);
        check("x3", int'(x3), m_x[3]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        if (done) n_done++;
    endtask

    task automatic drive(input int v, input bit val, input bit ab);
        din       = W'(v);
        din_valid = val;
        abort     = ab;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 1'b0, 1'b0);
    endtask

    task automatic batch(input int a, input int b, input int c, input int d);
        drive(a, 1'b1, 1'b0);
        drive(b, 1'b1, 1'b0);
        drive(c, 1'b1, 1'b0);
        drive(d, 1'b1, 1'b0);
    endtask

    // Asserts rst between edges, checks the asynchronous clear, holds it over
    // one edge and checks ready right after release.
    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        check_outputs();
        step();
        rst = 1'b0;
        #1;
        check_outputs();
    endtask

    initial begin
        int vals[4];
        int pat[7];
        int idx;
        int done_before;

        rst = 1'b1; din = '0; din_valid = 1'b0; abort = 1'b0;
        model_clear();
        #3;
        check_outputs();
        step();
        rst = 1'b0;
        #1;
        check_outputs();

        // Basic batch
        batch(5, 2, 7, 1);
        idle(SC + 3);

        // Gapped source
        vals = '{3, 6, 0, 4};
        pat  = '{1, 0, 0, 1, 0, 1, 1};
        idx  = 0;
        for (int i = 0; i < 7; i++) begin
            drive(vals[idx], pat[i] != 0, 1'b0);
            if (pat[i] != 0) idx++;
        end
        idle(SC + 3);

        // Abort drops the same-edge accept
        drive(6, 1'b1, 1'b0);
        drive(2, 1'b1, 1'b0);
        drive(7, 1'b1, 1'b1);
        batch(1, 1, 0, 0);
        idle(SC + 3);

        // Back-pressure through LOAD/WAIT/DONE
        batch(5, 2, 7, 1);
        for (int i = 0; i < SC + 5; i++) drive(4, 1'b1, 1'b0);
        idle(SC + 3);

        // Reset two cycles into WAIT
        batch(3, 1, 2, 0);
        idle(3);
        done_before = n_done;
        pulse_reset();
        idle(SC + 4);
        check("no_done_after_rst", n_done, done_before);

        // Boundary values
        done_before = n_done;
        batch(7, 7, 7, 7);
        idle(SC + 3);
        batch(0, 0, 0, 0);
        idle(SC + 3);
        check("done_per_batch", n_done - done_before, 2);

        // Random traffic with occasional aborts and resets
        for (int i = 0; i < 1500; i++) begin
            if (i % 311 == 157) pulse_reset();
            drive(int'($urandom_range(0, 7)), ($urandom % 3) != 0, ($urandom % 20) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
